// File: rtl/imem_load_ctrl.sv
// Packs a little-endian byte stream into 32-bit words and writes them into the instruction memory.
// A word is written one cycle after its 4th byte is accepted. byte_ready is high only in LOAD, and fetch stalls until the load is done.
module imem_load_ctrl #(
  parameter int  DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  input  logic          byte_last,
  output logic          byte_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  input  logic          fetch_req,
  output logic          fetch_grant,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [AW:0]   word_count
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  state_t      state;
  logic [1:0]  lane;
  logic [31:0] asm_word;
  logic [31:0] next_word;
  logic [31:0] commit_word;
  logic        accept;
  logic        commit;
  logic        full;

  assign byte_ready  = (state == LOAD);
  assign busy        = (state == LOAD) | (state == FLUSH);
  assign fetch_grant = fetch_req & ((state == IDLE) | (state == DONE));
  assign accept      = byte_valid & byte_ready;
  assign full        = (word_count == CAP);

  always_comb begin
    next_word = asm_word;
    next_word[{lane, 3'b000} +: 8] = byte_data;
  end

  // A word leaves either on its 4th byte or as the zero-padded tail in FLUSH.
  assign commit      = (accept & (lane == 2'd3)) | (state == FLUSH);
  assign commit_word = (state == FLUSH) ? asm_word : next_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lane       <= 2'd0;
      asm_word   <= 32'd0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= 32'd0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we <= 1'b0;

      if (commit) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          mem_we     <= 1'b1;
          mem_waddr  <= word_count[AW-1:0];
          mem_wdata  <= commit_word;
          word_count <= word_count + ONE;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            lane       <= 2'd0;
            asm_word   <= 32'd0;
            word_count <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (lane == 2'd3) begin
              asm_word <= 32'd0;
              lane     <= 2'd0;
              if (byte_last) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              asm_word <= next_word;
              lane     <= lane + 2'd1;
              if (byte_last) state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          asm_word <= 32'd0;
          lane     <= 2'd0;
          state    <= DONE;
          done     <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench: one 256-word and one 4-word controller driven by the same byte stream.
module tb_imem_load_ctrl;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start, byte_valid, byte_last, fetch_req;
  logic [7:0] byte_data;

  logic        a_byte_ready, a_mem_we, a_fetch_grant, a_busy, a_done, a_overflow;
  logic [7:0]  a_mem_waddr;
  logic [31:0] a_mem_wdata;
  logic [8:0]  a_word_count;

  logic        b_byte_ready, b_mem_we, b_fetch_grant, b_busy, b_done, b_overflow;
  logic [1:0]  b_mem_waddr;
  logic [31:0] b_mem_wdata;
  logic [2:0]  b_word_count;

  exp_t       qa[$];
  exp_t       qb[$];
  int         wa_cyc[$];
  logic [7:0] prog[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_load_ctrl #(.DEPTH(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(a_byte_ready),
    .mem_we(a_mem_we), .mem_waddr(a_mem_waddr), .mem_wdata(a_mem_wdata),
    .fetch_req(fetch_req), .fetch_grant(a_fetch_grant), .busy(a_busy),
    .done(a_done), .overflow(a_overflow), .word_count(a_word_count)
  );

  imem_load_ctrl #(.DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(b_byte_ready),
    .mem_we(b_mem_we), .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata),
    .fetch_req(fetch_req), .fetch_grant(b_fetch_grant), .busy(b_busy),
    .done(b_done), .overflow(b_overflow), .word_count(b_word_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitors: every write strobe must match the oldest expected word.
  always @(negedge clk) begin
    exp_t e;
    if (a_mem_we) begin
      if (qa.size() == 0) chk("a_unexpected_write", {32'(a_mem_waddr), a_mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = qa.pop_front();
        chk("a_write", {32'(a_mem_waddr), a_mem_wdata}, {32'(e.addr), e.data});
        wa_cyc.push_back(cyc);
      end
    end
    if (b_mem_we) begin
      if (qb.size() == 0) chk("b_unexpected_write", {32'(b_mem_waddr), b_mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = qb.pop_front();
        chk("b_write", {32'(b_mem_waddr), b_mem_wdata}, {32'(e.addr), e.data});
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_a_zero"}, {a_byte_ready, a_mem_we, a_mem_waddr, a_mem_wdata, a_busy,
                           a_done, a_overflow, a_word_count, a_fetch_grant}, 64'd0);
    chk({tag, "_b_zero"}, {b_byte_ready, b_mem_we, b_mem_waddr, b_mem_wdata, b_busy,
                           b_done, b_overflow, b_word_count, b_fetch_grant}, 64'd0);
  endtask

  task automatic push_exp(input int addr, input logic [31:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    qa.push_back(e);
    if (addr < 4) qb.push_back(e);
  endtask

  // gap < 0 selects a rotating 1..3 cycle gap; byte_last is driven high in gaps with valid low.
  task automatic run_load(input int gap, input bit mid_start, input int wc_a, input int wc_b, input bit ovf_b);
    int nw;
    int g;
    logic [31:0] w;
    nw = (prog.size() + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++)
        if (4*i + k < prog.size()) w[8*k +: 8] = prog[4*i + k];
      push_exp(i, w);
    end
    fetch_req = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < prog.size(); i++) begin
      byte_valid = 1'b1;
      byte_data  = prog[i];
      byte_last  = (i == prog.size() - 1);
      start      = mid_start && (i == prog.size() / 2);
      chk("a_ready_load", a_byte_ready, 1);
      chk("a_grant_load", a_fetch_grant, 0);
      chk("b_grant_load", b_fetch_grant, 0);
      @(posedge clk); #1;
      start = 1'b0;
      byte_valid = 1'b0;
      g = (gap < 0) ? (i % 3) + 1 : gap;
      for (int j = 0; j < g; j++) begin
        byte_last = 1'b1;
        byte_data = 8'hEE;
        @(posedge clk); #1;
      end
      byte_last = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("a_done", a_done, 1);
    chk("b_done", b_done, 1);
    chk("a_busy", a_busy, 0);
    chk("a_word_count", a_word_count, wc_a);
    chk("b_word_count", b_word_count, wc_b);
    chk("a_overflow", a_overflow, 0);
    chk("b_overflow", b_overflow, ovf_b);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    chk("a_grant_after", a_fetch_grant, 1);
    fetch_req = 1'b0;
    #1;
    chk("a_grant_released", a_fetch_grant, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
    byte_data = 8'h00; fetch_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b1;
    #1;
    chk("a_grant_idle", a_fetch_grant, 1);
    fetch_req = 1'b0;

    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(0, 0, 2, 2, 0);

    prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
    run_load(0, 0, 2, 2, 0);

    prog = '{};
    for (int i = 0; i < 16; i++) prog.push_back(8'(8'h40 + i));
    wa_cyc = '{};
    run_load(0, 0, 4, 4, 0);
    chk("spacing_count", wa_cyc.size(), 4);
    for (int i = 1; i < 4; i++)
      if (i < wa_cyc.size()) chk("spacing_b2b", wa_cyc[i] - wa_cyc[i-1], 4);
    run_load(-1, 0, 4, 4, 0);

    prog = '{};
    for (int i = 0; i < 20; i++) prog.push_back(8'(8'hA0 + i));
    run_load(1, 0, 5, 4, 1);

    prog = '{};
    for (int i = 0; i < 12; i++) prog.push_back(8'(8'h10 * i + 1));
    run_load(0, 1, 3, 3, 0);

    // Abandon a load mid-word: the first word stays written, state returns to IDLE.
    push_exp(0, 32'h04030201);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'(i + 1);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    chk("midreset_queue", qa.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    prog = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(0, 0, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
